// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } txState_t;

    localparam logic cLineIdle = 1'b1;
    localparam logic cStartBit = 1'b0;

    // 12 MHz system clock, 115200 baud
    localparam int unsigned cClksPerBit115200At12M = 104;

endpackage

// File: rtl/uart_fifo_tx_if.sv
// FIFO read port as seen by a consumer: pop strobe, read data, empty flag.
interface uart_fifo_tx_if #(
    parameter int unsigned pDataWidth = 8
);
    logic                  readEn;
    logic [pDataWidth-1:0] readData;
    logic                  fifoEmpty;

    // consumer (transmitter) side
    modport master (
        output readEn,
        input  readData,
        input  fifoEmpty
    );

    // FIFO side
    modport slave (
        input  readEn,
        output readData,
        output fifoEmpty
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..pClksPerBit-1 and flags the last count of each bit.
// iClr holds the counter at zero so the first bit after a restart is full length.
module uart_baud_gen #(
    parameter int unsigned pClksPerBit = 104
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iClr,
    output logic oBitTick
);

    localparam int unsigned cCntW = (pClksPerBit > 1) ? $clog2(pClksPerBit) : 1;
    localparam logic [cCntW-1:0] cLastCnt = cCntW'(pClksPerBit - 1);

    logic [cCntW-1:0] cnt;

    // Free-running bit counter, reloading at each bit boundary or on restart
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt <= '0;
        end else if (iClr || (cnt == cLastCnt)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oBitTick = !iClr && (cnt == cLastCnt);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART 8N1 transmitter draining a byte FIFO through its read port.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int unsigned pClksPerBit = cClksPerBit115200At12M,
    parameter int unsigned pDataWidth  = 8
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iTxEnable,
    uart_fifo_tx_if.master        fifoRd,
    output logic                  oTx,
    output logic                  oBusy,
    output logic                  oTxDone
);

    localparam int unsigned cBitCntW = $clog2(pDataWidth + 1);
    localparam logic [cBitCntW-1:0] cLastBit = cBitCntW'(pDataWidth - 1);

    txState_t              state;
    txState_t              stateNext;
    logic [pDataWidth-1:0] shiftReg;
    logic [pDataWidth-1:0] shiftNext;
    logic [cBitCntW-1:0]   bitCnt;
    logic [cBitCntW-1:0]   bitCntNext;
    logic                  txReg;
    logic                  txNext;
    logic                  bitTick;
    logic                  baudClr;
    logic                  canStart;

`ifdef UART_TX_PARITY_EN
    logic                  parityReg;

    // Even parity of the byte captured in LOAD, held for the parity bit
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            parityReg <= 1'b0;
        end else if (state == LOAD) begin
            parityReg <= ^fifoRd.readData;
        end
    end
`endif

    // Baud timer is held at zero until the start bit begins
    assign baudClr = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_baud_gen #(
        .pClksPerBit (pClksPerBit)
    ) baudGen (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iClr     (baudClr),
        .oBitTick (bitTick)
    );

    assign canStart = iTxEnable && !fifoRd.fifoEmpty;

    // State, shift register, bit counter and the registered line driver
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            txReg    <= cLineIdle;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitCnt   <= bitCntNext;
            txReg    <= txNext;
        end
    end

    // Next-state logic; the line level is computed from the next state so the
    // flopped oTx lines up with the state register
    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        txNext     = cLineIdle;

        case (state)
            IDLE: begin
                if (canStart) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                stateNext = LOAD;
            end
            LOAD: begin
                shiftNext = fifoRd.readData;
                stateNext = START;
            end
            START: begin
                if (bitTick) begin
                    bitCntNext = '0;
                    stateNext  = DATA;
                end
            end
            DATA: begin
                if (bitTick) begin
                    shiftNext = shiftReg >> 1;
                    if (bitCnt == cLastBit) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end else begin
                        bitCntNext = bitCnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitTick) begin
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (bitTick) begin
                    stateNext = canStart ? FETCH : IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        case (stateNext)
            START:   txNext = cStartBit;
            DATA:    txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txNext = parityReg;
`endif
            default: txNext = cLineIdle;
        endcase
    end

    assign fifoRd.readEn = (state == FETCH);
    assign oTx           = txReg;
    assign oBusy         = (state != IDLE);
    assign oTxDone       = (state == STOP) && bitTick;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx with a behavioural 16-deep FIFO on the read port.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

    localparam int unsigned cClks = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned cFrameLen = 2 + 11 * cClks;
`else
    localparam int unsigned cFrameLen = 2 + 10 * cClks;
`endif
    localparam int cWaitLimit = 200;
    localparam int cFifoDepth = 16;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic txEnable = 1'b0;
    logic tx;
    logic busy;
    logic txDone;

    int errCount = 0;
    int checkCount = 0;

    uart_fifo_tx_if #(.pDataWidth(8)) fifoIf ();

    uart_fifo_tx #(
        .pClksPerBit (cClks),
        .pDataWidth  (8)
    ) dut (
        .iClk      (clk),
        .iRstN     (rstN),
        .iTxEnable (txEnable),
        .fifoRd    (fifoIf.master),
        .oTx       (tx),
        .oBusy     (busy),
        .oTxDone   (txDone)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO; the pop strobe is sampled at negedge to avoid edge races
    logic [7:0] fifoQ[$];
    logic       wrEn = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       readEnS = 1'b0;
    int         underflowCount = 0;
    int         overflowCount = 0;

    always @(negedge clk) readEnS = fifoIf.readEn;

    always @(posedge clk) begin
        if (readEnS) begin
            if (fifoQ.size() == 0) underflowCount++;
            else fifoIf.readData <= fifoQ.pop_front();
        end
        if (wrEn) begin
            if (fifoQ.size() >= cFifoDepth) overflowCount++;
            else fifoQ.push_back(wrData);
        end
        fifoIf.fifoEmpty <= (fifoQ.size() == 0);
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic pushByte(input logic [7:0] b);
        wrData = b;
        wrEn = 1'b1;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    function automatic logic [63:0] expTx(input logic [7:0] b);
        logic [63:0] v;
        int unsigned slot;
        v = '0;
        v[0] = 1'b1;
        v[1] = 1'b1;
        for (int unsigned i = 2; i < cFrameLen; i++) begin
            slot = (i - 2) / cClks;
            if (slot == 0) v[i] = 1'b0;
            else if (slot <= 8) v[i] = b[slot-1];
`ifdef UART_TX_PARITY_EN
            else if (slot == 9) v[i] = ^b;
`endif
            else v[i] = 1'b1;
        end
        return v;
    endfunction

    // Waits (bounded) for the pop strobe, then records one whole frame from FETCH
    task automatic runFrame(input string tag, input logic [7:0] b, output int waited,
                            output logic [63:0] txV);
        logic [63:0] reV;
        logic [63:0] buV;
        logic [63:0] dnV;
        logic [7:0]  dec;
        waited = 0;
        txV = '0;
        reV = '0;
        buV = '0;
        dnV = '0;
        while (fifoIf.readEn !== 1'b1 && waited < cWaitLimit) begin
            @(negedge clk);
            waited++;
        end
        checkVal({tag, "_fetch"}, 64'(fifoIf.readEn), 64'd1);
        if (fifoIf.readEn !== 1'b1) return;
        for (int unsigned i = 0; i < cFrameLen; i++) begin
            txV[i] = tx;
            reV[i] = fifoIf.readEn;
            buV[i] = busy;
            dnV[i] = txDone;
            @(negedge clk);
        end
        for (int unsigned k = 0; k < 8; k++) dec[k] = txV[2 + cClks * (k + 1) + cClks / 2];
        checkVal({tag, "_line"}, txV, expTx(b));
        checkVal({tag, "_data"}, 64'(dec), 64'(b));
        checkVal({tag, "_readEn"}, reV, 64'd1);
        checkVal({tag, "_busy"}, buV, (64'd1 << cFrameLen) - 64'd1);
        checkVal({tag, "_done"}, dnV, 64'd1 << (cFrameLen - 1));
    endtask

    task automatic quietCycles(input int n, output int pops, output int lows);
        pops = 0;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            if (fifoIf.readEn !== 1'b0) pops++;
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pops;
        int lows;
        logic [63:0] txV;

        // Reset state
        repeat (3) @(negedge clk);
        checkVal("rstTx", 64'(tx), 64'd1);
        checkVal("rstReadEn", 64'(fifoIf.readEn), 64'd0);
        checkVal("rstBusy", 64'(busy), 64'd0);
        checkVal("rstDone", 64'(txDone), 64'd0);
        rstN = 1'b1;
        txEnable = 1'b1;
        quietCycles(20, pops, lows);
        checkVal("emptyNoPop", 64'(pops), 64'd0);
        checkVal("emptyTxHigh", 64'(lows), 64'd0);

        // Single byte 0xA5: line 1,1, start, 1,0,1,0,0,1,0,1, stop
        pushByte(8'hA5);
        runFrame("a5", 8'hA5, w, txV);
        checkVal("a5Bit0", 64'(txV[6]), 64'd1);
        checkVal("a5Bit1", 64'(txV[10]), 64'd0);
        checkVal("a5Idle", 64'(busy), 64'd0);
        quietCycles(20, pops, lows);
        checkVal("a5NoExtraPop", 64'(pops), 64'd0);

        // Burst of 16 bytes, back-to-back frames with a two-clock gap
        fork
            begin
                for (int k = 1; k <= 16; k++) pushByte(8'(k));
            end
            begin
                for (int k = 1; k <= 16; k++) begin
                    runFrame($sformatf("burst%0d", k), 8'(k), w, txV);
                    if (k > 1) checkVal($sformatf("burstGap%0d", k), 64'(w), 64'd0);
                end
            end
        join
        checkVal("burstIdle", 64'(busy), 64'd0);

        // Enable dropped during DATA: frame finishes, next pop waits for enable
        txEnable = 1'b0;
        pushByte(8'h3C);
        pushByte(8'h5A);
        txEnable = 1'b1;
        fork
            runFrame("en3c", 8'h3C, w, txV);
            begin
                repeat (14) @(negedge clk);
                txEnable = 1'b0;
            end
        join
        checkVal("enDropIdle", 64'(busy), 64'd0);
        quietCycles(30, pops, lows);
        checkVal("enDropNoPop", 64'(pops), 64'd0);
        checkVal("enDropTxHigh", 64'(lows), 64'd0);
        txEnable = 1'b1;
        runFrame("en5a", 8'h5A, w, txV);

        // Reset during data bit 3 of 0xFF; the queued 0x81 follows cleanly
        pushByte(8'hFF);
        pushByte(8'h81);
        w = 0;
        while (fifoIf.readEn !== 1'b1 && w < cWaitLimit) begin
            @(negedge clk);
            w++;
        end
        checkVal("ffFetch", 64'(fifoIf.readEn), 64'd1);
        repeat (2 + cClks * 4 + 1) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkVal("midRstTx", 64'(tx), 64'd1);
        checkVal("midRstBusy", 64'(busy), 64'd0);
        checkVal("midRstReadEn", 64'(fifoIf.readEn), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        runFrame("after81", 8'h81, w, txV);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        pushByte(8'h07);
        runFrame("par07", 8'h07, w, txV);
        checkVal("par07Bit", 64'(txV[2 + 9 * cClks + cClks / 2]), 64'd1);
        pushByte(8'h03);
        runFrame("par03", 8'h03, w, txV);
        checkVal("par03Bit", 64'(txV[2 + 9 * cClks + cClks / 2]), 64'd0);
`endif

        repeat (4) @(negedge clk);
        checkVal("underflow", 64'(underflowCount), 64'd0);
        checkVal("overflow", 64'(overflowCount), 64'd0);
        checkVal("fifoDrained", 64'(fifoQ.size()), 64'd0);
        checkVal("finalIdle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
